// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU / response bundle for alu_cmd_issuer.
// master = the issuer, slave = producer, ALU and consumer side.
interface alu_cmd_issuer_if #(
  parameter int DEPTH = 4
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [31:0]                  cmd_a;
  logic [31:0]                  cmd_b;
  logic                         cmd_sv;
  logic                         cmd_op_prefix;
  logic [7:0]                   cmd_op;

  logic                         alu_start;
  logic [31:0]                  alu_a;
  logic [31:0]                  alu_b;
  logic                         alu_sv;
  logic                         alu_op_prefix;
  logic [7:0]                   alu_op;
  logic                         alu_done;
  logic [63:0]                  alu_result;
  logic [7:0]                   alu_err;
  logic                         alu_gp;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [63:0]                  rsp_result;
  logic [7:0]                   rsp_err;
  logic                         rsp_gp;
  logic [7:0]                   rsp_op;

  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_sv, cmd_op_prefix, cmd_op,
    output cmd_ready,
    output alu_start, alu_a, alu_b, alu_sv, alu_op_prefix, alu_op,
    input  alu_done, alu_result, alu_err, alu_gp,
    output rsp_valid, rsp_result, rsp_err, rsp_gp, rsp_op,
    input  rsp_ready,
    output count, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_sv, cmd_op_prefix, cmd_op,
    input  cmd_ready,
    input  alu_start, alu_a, alu_b, alu_sv, alu_op_prefix, alu_op,
    output alu_done, alu_result, alu_err, alu_gp,
    input  rsp_valid, rsp_result, rsp_err, rsp_gp, rsp_op,
    output rsp_ready,
    input  count, busy
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command FIFO + one-at-a-time ALU start/done driver with in-order response stream.
// Optional issue watchdog enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_cmd_issuer #(
  parameter int DEPTH          = 4,
  parameter int MAX_OP         = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  alu_cmd_issuer_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sv;
    logic        op_prefix;
    logic [7:0]  op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            push;
  logic            pop;

  assign head          = mem[rd_ptr];
  assign bus.cmd_ready = (count_q != CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count_q != '0);
  assign bus.count     = count_q;
  assign bus.busy      = (state != IDLE) || (count_q != '0);

  // Illegal parameter combinations leave this hook empty; nothing is generated.
  if (DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_hook
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, sv: bus.cmd_sv,
                       op_prefix: bus.cmd_op_prefix, op: bus.cmd_op};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bus.alu_start     <= 1'b0;
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.alu_sv        <= 1'b0;
      bus.alu_op_prefix <= 1'b0;
      bus.alu_op        <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_result    <= '0;
      bus.rsp_err       <= '0;
      bus.rsp_gp        <= 1'b0;
      bus.rsp_op        <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      tcnt              <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.alu_start <= 1'b0;
          if (pop) begin
            if (head.op <= 8'(MAX_OP)) begin
              bus.alu_a         <= head.a;
              bus.alu_b         <= head.b;
              bus.alu_sv        <= head.sv;
              bus.alu_op_prefix <= head.op_prefix;
              bus.alu_op        <= head.op;
              bus.alu_start     <= 1'b1;
              state             <= ISSUE;
`ifdef ALU_ISSUE_TIMEOUT_EN
              tcnt              <= '0;
`endif
            end else begin
              // Rejected locally: answer without touching the ALU.
              bus.rsp_result <= '0;
              bus.rsp_err    <= 8'hFE;
              bus.rsp_gp     <= 1'b0;
              bus.rsp_op     <= head.op;
              bus.rsp_valid  <= 1'b1;
              state          <= RESP;
            end
          end
        end
        ISSUE: begin
          if (bus.alu_done) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_err    <= bus.alu_err;
            bus.rsp_gp     <= bus.alu_gp;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_valid  <= 1'b1;
            bus.alu_start  <= 1'b0;
            state          <= RESP;
          end
`ifdef ALU_ISSUE_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_result <= '0;
            bus.rsp_err    <= 8'hFD;
            bus.rsp_gp     <= 1'b0;
            bus.rsp_op     <= bus.alu_op;
            bus.rsp_valid  <= 1'b1;
            bus.alu_start  <= 1'b0;
            state          <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RESP: begin
          bus.alu_start <= 1'b0;
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: vector table plus multi-cycle corner sequences.
// Define ALU_ISSUE_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_alu_cmd_issuer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.DEPTH(4)) bus ();

  alu_cmd_issuer #(.DEPTH(4), .MAX_OP(10), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          total = 0;
  int          bad = 0;
  int          lat = 3;
  bit          hold = 1'b0;
  bit          stray = 1'b0;
  int          cyc = 0;
  logic [63:0] rsp_q [$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic [63:0] res;
    logic [7:0]  err;
    logic        gp;
  } vec_t;
  vec_t vecs [7];

  // ALU model: op 2 multiplies, everything else adds; op 4 reports err 0x33.
  always @(negedge clk) begin
    if (stray) bus.alu_done = 1'b1;
    else if (hold || !bus.alu_start) begin
      bus.alu_done = 1'b0;
      cyc = 0;
    end else begin
      cyc++;
      bus.alu_done = (cyc >= lat);
    end
    bus.alu_result = (bus.alu_op == 8'd2) ? 64'(bus.alu_a) * 64'(bus.alu_b)
                                          : 64'(bus.alu_a) + 64'(bus.alu_b);
    bus.alu_err    = (bus.alu_op == 8'd4) ? 8'h33 : 8'h00;
    bus.alu_gp     = (bus.alu_op == 8'd2);
  end

  always @(negedge clk)
    if (!reset && bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_result);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    int n = 0;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin tick(); n++; end
    if (!bus.cmd_ready) expire("push");
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.rsp_valid && n < 60) begin tick(); n++; end
    if (!bus.rsp_valid) expire(nm);
  endtask

  task automatic take_rsp(input string nm, output logic [63:0] res, output logic [7:0] err,
                          output logic gp, output logic [7:0] op);
    wait_valid(nm);
    res = bus.rsp_result; err = bus.rsp_err; gp = bus.rsp_gp; op = bus.rsp_op;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    logic [7:0]  e;
    logic [7:0]  o;
    logic        g;
    int          acc;
    int          n;
    bit          take;

    vecs[0] = '{32'd5,        32'd7, 8'd1,   64'd12,           8'h00, 1'b0};
    vecs[1] = '{32'd6,        32'd7, 8'd2,   64'd42,           8'h00, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'd1, 8'd1,   64'h1_0000_0000,  8'h00, 1'b0};
    vecs[3] = '{32'd3,        32'd4, 8'd10,  64'd7,            8'h00, 1'b0};
    vecs[4] = '{32'd1,        32'd1, 8'd4,   64'd2,            8'h33, 1'b0};
    vecs[5] = '{32'd8,        32'd9, 8'd11,  64'd0,            8'hFE, 1'b0};
    vecs[6] = '{32'd1,        32'd2, 8'd255, 64'd0,            8'hFE, 1'b0};

    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.cmd_sv = 1'b0; bus.cmd_op_prefix = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_alu_start", bus.alu_start, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);

    // Issue latency for add 5+7 with a 3-cycle ALU.
    lat = 3;
    bus.cmd_sv = 1'b1;
    push(5, 7, 1);
    chk("lat_e_start", bus.alu_start, 0);
    chk("lat_e_count", bus.count, 1);
    tick();
    chk("lat_e1_start", bus.alu_start, 1);
    chk("lat_e1_a", bus.alu_a, 5);
    chk("lat_e1_b", bus.alu_b, 7);
    chk("lat_e1_op", bus.alu_op, 1);
    chk("lat_e1_sv", bus.alu_sv, 1);
    chk("lat_e1_count", bus.count, 0);
    tick();
    chk("lat_e2_start", bus.alu_start, 1);
    tick();
    chk("lat_e3_start", bus.alu_start, 1);
    tick();
    chk("lat_d_start", bus.alu_start, 0);
    chk("lat_d_valid", bus.rsp_valid, 1);
    chk("lat_d_result", bus.rsp_result, 12);
    chk("lat_d_err", bus.rsp_err, 0);
    chk("lat_d_op", bus.rsp_op, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("lat_hs_valid", bus.rsp_valid, 0);
    bus.cmd_sv = 1'b0;

    // Table of single commands.
    lat = 2;
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op);
      take_rsp($sformatf("vec%0d_wait", i), r, e, g, o);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_gp", i), g, vecs[i].gp);
      chk($sformatf("vec%0d_op", i), o, vecs[i].op);
    end

    // Illegal opcode: response one cycle after the pop, ALU untouched.
    push(9, 9, 8'd11);
    tick();
    chk("ill_valid", bus.rsp_valid, 1);
    chk("ill_start", bus.alu_start, 0);
    chk("ill_err", bus.rsp_err, 8'hFE);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Capacity: DEPTH queued plus one in flight while done is held off.
    hold = 1'b1; lat = 1; rsp_q.delete(); acc = 0;
    bus.cmd_a = 32'd100; bus.cmd_b = 32'd1; bus.cmd_op = 8'd1; bus.cmd_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      take = bus.cmd_ready;
      tick();
      if (take) begin acc++; bus.cmd_a = 32'(100 + acc); end
    end
    bus.cmd_valid = 1'b0;
    chk("cap_accepted", acc, 5);
    chk("cap_ready", bus.cmd_ready, 0);
    chk("cap_count", bus.count, 4);
    chk("cap_busy", bus.busy, 1);
    hold = 1'b0; bus.rsp_ready = 1'b1; n = 0;
    while (rsp_q.size() < 5 && n < 100) begin tick(); n++; end
    bus.rsp_ready = 1'b0;
    if (rsp_q.size() < 5) expire("cap_drain");
    else for (int i = 0; i < 5; i++) chk($sformatf("cap_rsp%0d", i), rsp_q[i], 64'(101 + i));

    // Backpressure: mul 6*7 held while consumer stalls, next command waits.
    lat = 2;
    push(6, 7, 2);
    push(1, 2, 1);
    wait_valid("bp_wait");
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 42);
      chk("bp_start", bus.alu_start, 0);
      tick();
    end
    chk("bp_count", bus.count, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_hs_start", bus.alu_start, 0);
    chk("bp_hs_valid", bus.rsp_valid, 0);
    tick();
    chk("bp_next_start", bus.alu_start, 1);
    chk("bp_next_op", bus.alu_op, 1);
    take_rsp("bp_next_wait", r, e, g, o);
    chk("bp_next_result", r, 3);

    // Stray done while idle is ignored.
    stray = 1'b1;
    repeat (3) tick();
    chk("stray_valid", bus.rsp_valid, 0);
    chk("stray_busy", bus.busy, 0);
    stray = 1'b0;
    tick();

    // Reset during ISSUE with two queued commands.
    hold = 1'b1;
    push(1, 1, 1);
    push(2, 2, 1);
    push(3, 3, 1);
    chk("mid_pre_start", bus.alu_start, 1);
    chk("mid_pre_count", bus.count, 2);
    reset = 1'b1;
    tick();
    chk("mid_start", bus.alu_start, 0);
    chk("mid_valid", bus.rsp_valid, 0);
    chk("mid_count", bus.count, 0);
    chk("mid_ready", bus.cmd_ready, 1);
    reset = 1'b0; hold = 1'b0; rsp_q.delete(); bus.rsp_ready = 1'b1;
    repeat (10) tick();
    bus.rsp_ready = 1'b0;
    chk("mid_no_rsp", rsp_q.size(), 0);
    chk("mid_busy", bus.busy, 0);

`ifdef ALU_ISSUE_TIMEOUT_EN
    // Watchdog: 16 cycles of start without done, then 0xFD; next command runs normally.
    hold = 1'b1; lat = 2;
    push(4, 4, 1);
    push(5, 5, 1);
    n = 0;
    while (bus.alu_start && n < 40) begin n++; tick(); end
    chk("to_len", n, 16);
    chk("to_valid", bus.rsp_valid, 1);
    chk("to_err", bus.rsp_err, 8'hFD);
    chk("to_result", bus.rsp_result, 0);
    hold = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    take_rsp("to_next_wait", r, e, g, o);
    chk("to_next_result", r, 10);
    chk("to_next_err", e, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
